// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b physical-memory arbiter: bus widths, line type,
// grant FSM states and the round-robin side marker.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LINE_W_DEF = 128;

  typedef logic [ADDR_W_DEF-1:0] lc3b_word;
  typedef logic [LINE_W_DEF-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way round-robin selector: a lone requester always wins,
// and on a tie the side that was not granted last time wins.
module arb_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output logic   grant_i,
  output logic   grant_d
);

  always_comb begin
    grant_i = req_i && (!req_d || (last_grant == GRANT_D));
    grant_d = req_d && (!req_i || (last_grant == GRANT_I));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single pmem port between the I-cache miss path and the
// D-cache miss/writeback path; the granted command is latched until pmem_resp.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;

  logic d_req;
  logic grant_i, grant_d;
  logic serving;

  assign d_req = d_read || d_write;

  arb_rr_pick u_rr_pick (
    .req_i      (i_read),
    .req_d      (d_req),
    .last_grant (last_grant_q),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_resp_d     = 1'b0;
    d_resp_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = SERVE_I;
          addr_d       = i_addr;
          wr_d         = 1'b0;
          last_grant_d = GRANT_I;
        end else if (grant_d) begin
          state_d      = SERVE_D;
          addr_d       = d_addr;
          wdata_d      = d_wdata;
          wr_d         = d_write;  // read+write together is a writeback
          last_grant_d = GRANT_D;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          i_rdata_d = pmem_rdata;
          i_resp_d  = 1'b1;
          state_d   = DONE;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          d_rdata_d = pmem_rdata;
          d_resp_d  = 1'b1;
          state_d   = DONE;
        end
      end
      // DONE never grants, so a request still held during the resp cycle is not re-served.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_resp_q     <= i_resp_d;
      d_resp_q     <= d_resp_d;
    end
  end

  assign serving    = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign pmem_read  = serving && !wr_q;
  assign pmem_write = serving && wr_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign i_resp     = i_resp_q;
  assign d_resp     = d_resp_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected pmem
// commands and cache responses; monitor and pmem responder run independently.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  typedef struct {
    logic     wr;
    lc3b_word addr;
    lc3b_line wdata;
  } cmd_t;

  cmd_t     exp_cmd_q[$];
  lc3b_line exp_i_q[$];
  lc3b_line exp_d_q[$];
  lc3b_line rd_q[$];

  int checks = 0;
  int errors = 0;

  int pm_lat    = 2;
  bit pm_enable = 1'b1;
  int pm_cnt    = 0;
  bit pm_fired  = 1'b0;

  bit   mon_prev_active = 1'b0;
  bit   mon_prev_i      = 1'b0;
  bit   mon_prev_d      = 1'b0;
  cmd_t mon_cur;
  cmd_t mon_exp;

  localparam lc3b_line L_DEADBEEF = 128'hDEAD0000_11112222_33334444_5555BEEF;
  localparam lc3b_line L_WB       = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
  localparam lc3b_line L_D1       = 128'hD1D1D1D1_00000000_00000000_0000D1D1;
  localparam lc3b_line L_I1       = 128'h1111AAAA_00000000_00000000_0000A1A1;
  localparam lc3b_line L_D2       = 128'hD2D2D2D2_00000000_00000000_0000D2D2;
  localparam lc3b_line L_I2       = 128'h2222BBBB_00000000_00000000_0000B2B2;
  localparam lc3b_line L_ACK      = 128'hACAC_0000_0000_0000_0000_0000_0000_ACAC;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic wr, input lc3b_word a, input lc3b_line wd);
    cmd_t c;
    c.wr = wr;
    c.addr = a;
    c.wdata = wd;
    exp_cmd_q.push_back(c);
  endtask

  // pmem model: answers each command after pm_lat sampled cycles
  initial begin : responder
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pm_enable) begin
        pmem_resp = 1'b0;
        if ((pmem_read || pmem_write) && !pm_fired) begin
          pm_cnt++;
          if (pm_cnt >= pm_lat) begin
            if (rd_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL pmem_model: command with no queued rdata (t=%0t)", $time);
            end else begin
              pmem_rdata = rd_q.pop_front();
            end
            pmem_resp = 1'b1;
            pm_fired  = 1'b1;
          end
        end else if (!(pmem_read || pmem_write)) begin
          pm_cnt   = 0;
          pm_fired = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        check("pmem_rw_exclusive", {127'd0, pmem_read && pmem_write}, 128'd0);
        if (!mon_prev_active) begin
          if (exp_cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_unexpected: got addr %h write %0b want none", pmem_addr, pmem_write);
          end else begin
            mon_exp = exp_cmd_q.pop_front();
            check("cmd_write", {127'd0, pmem_write}, {127'd0, mon_exp.wr});
            check("cmd_addr", {112'd0, pmem_addr}, {112'd0, mon_exp.addr});
            if (mon_exp.wr) check("cmd_wdata", pmem_wdata, mon_exp.wdata);
          end
          mon_cur.wr    = pmem_write;
          mon_cur.addr  = pmem_addr;
          mon_cur.wdata = pmem_wdata;
        end else begin
          check("cmd_stable_write", {127'd0, pmem_write}, {127'd0, mon_cur.wr});
          check("cmd_stable_addr", {112'd0, pmem_addr}, {112'd0, mon_cur.addr});
          check("cmd_stable_wdata", pmem_wdata, mon_cur.wdata);
        end
      end
      if (i_resp) begin
        check("i_resp_one_cycle", {127'd0, mon_prev_i}, 128'd0);
        if (exp_i_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL i_resp_unexpected: got i_resp=1 want 0 (t=%0t)", $time);
        end else begin
          check("i_rdata", i_rdata, exp_i_q.pop_front());
        end
      end
      if (d_resp) begin
        check("d_resp_one_cycle", {127'd0, mon_prev_d}, 128'd0);
        if (exp_d_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d_resp_unexpected: got d_resp=1 want 0 (t=%0t)", $time);
        end else begin
          check("d_rdata", d_rdata, exp_d_q.pop_front());
        end
      end
      mon_prev_active = pmem_read || pmem_write;
      mon_prev_i      = i_resp;
      mon_prev_d      = d_resp;
    end
  end

  task automatic run_i(input lc3b_word a, input bit chk_lat);
    int k;
    @(negedge clk);
    i_read = 1'b1;
    i_addr = a;
    if (chk_lat) begin
      @(negedge clk);
      check("i_first_cycle_read", {127'd0, pmem_read}, 128'd1);
      check("i_first_cycle_addr", {112'd0, pmem_addr}, {112'd0, a});
    end
    for (k = 0; k < 60 && !i_resp; k++) @(negedge clk);
    if (!i_resp) begin
      checks++;
      errors++;
      $display("FAIL i_resp_timeout: got no i_resp want pulse for addr %h", a);
    end
    i_read = 1'b0;
  endtask

  task automatic run_d(input lc3b_word a, input lc3b_line wd, input logic rd, input logic wr);
    int k;
    @(negedge clk);
    d_read  = rd;
    d_write = wr;
    d_addr  = a;
    d_wdata = wd;
    for (k = 0; k < 60 && !d_resp; k++) @(negedge clk);
    if (!d_resp) begin
      checks++;
      errors++;
      $display("FAIL d_resp_timeout: got no d_resp want pulse for addr %h", a);
    end
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    rst     = 1'b1;
    i_read  = 1'b0;
    i_addr  = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_pmem_read", {127'd0, pmem_read}, 128'd0);
    check("rst_pmem_write", {127'd0, pmem_write}, 128'd0);
    check("rst_pmem_addr", {112'd0, pmem_addr}, 128'd0);
    check("rst_pmem_wdata", pmem_wdata, 128'd0);
    check("rst_i_rdata", i_rdata, 128'd0);
    check("rst_d_rdata", d_rdata, 128'd0);
    check("rst_resps", {126'd0, i_resp, d_resp}, 128'd0);
    rst = 1'b0;

    // Tie right after reset: D wins first, then strict alternation D,I,D,I.
    pm_lat = 2;
    push_cmd(1'b0, 16'h2000, '0); rd_q.push_back(L_D1); exp_d_q.push_back(L_D1);
    push_cmd(1'b0, 16'h1000, '0); rd_q.push_back(L_I1); exp_i_q.push_back(L_I1);
    push_cmd(1'b0, 16'h2010, '0); rd_q.push_back(L_D2); exp_d_q.push_back(L_D2);
    push_cmd(1'b0, 16'h1010, '0); rd_q.push_back(L_I2); exp_i_q.push_back(L_I2);
    fork
      begin run_d(16'h2000, '0, 1'b1, 1'b0); run_d(16'h2010, '0, 1'b1, 1'b0); end
      begin run_i(16'h1000, 1'b0); run_i(16'h1010, 1'b0); end
    join
    repeat (2) @(negedge clk);

    // I-only read with 3-cycle pmem latency.
    pm_lat = 3;
    push_cmd(1'b0, 16'h1230, '0); rd_q.push_back(L_DEADBEEF); exp_i_q.push_back(L_DEADBEEF);
    run_i(16'h1230, 1'b1);
    @(negedge clk);
    check("i_resp_dropped", {127'd0, i_resp}, 128'd0);
    check("i_rdata_held", i_rdata, L_DEADBEEF);
    check("idle_after_done", {126'd0, pmem_read, pmem_write}, 128'd0);

    // D writeback.
    push_cmd(1'b1, 16'h4000, L_WB); rd_q.push_back(L_ACK); exp_d_q.push_back(L_ACK);
    run_d(16'h4000, L_WB, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // Mid-serve change: D read at 0x4000, address moves and request drops.
    pm_lat = 4;
    push_cmd(1'b0, 16'h4000, '0); rd_q.push_back(L_D1); exp_d_q.push_back(L_D1);
    @(negedge clk);
    d_read = 1'b1;
    d_addr = 16'h4000;
    @(negedge clk);
    @(negedge clk);
    d_addr = 16'h5000;
    d_read = 1'b0;
    @(negedge clk);
    check("mid_serve_addr", {112'd0, pmem_addr}, 128'h4000);
    check("mid_serve_read", {127'd0, pmem_read}, 128'd1);
    for (k = 0; k < 60 && !d_resp; k++) @(negedge clk);
    check("mid_serve_d_resp", {127'd0, d_resp}, 128'd1);
    repeat (2) @(negedge clk);

    // d_read and d_write together: a write.
    pm_lat = 1;
    push_cmd(1'b1, 16'h6000, L_DEADBEEF); rd_q.push_back(L_ACK); exp_d_q.push_back(L_ACK);
    run_d(16'h6000, L_DEADBEEF, 1'b1, 1'b1);
    repeat (2) @(negedge clk);

    // Spurious pmem_resp while idle.
    pm_enable  = 1'b0;
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = L_I2;
    @(negedge clk);
    pmem_resp  = 1'b0;
    check("spurious_no_cmd", {126'd0, pmem_read, pmem_write}, 128'd0);
    @(negedge clk);
    check("spurious_i_rdata_held", i_rdata, L_DEADBEEF);
    pm_enable = 1'b1;
    pm_lat    = 2;
    push_cmd(1'b0, 16'h0ABC, '0); rd_q.push_back(L_I1); exp_i_q.push_back(L_I1);
    run_i(16'h0ABC, 1'b1);
    repeat (2) @(negedge clk);

    // Reset during SERVE_I: command abandoned, no resp, late pmem_resp ignored.
    pm_enable = 1'b0;
    push_cmd(1'b0, 16'h7000, '0);
    @(negedge clk);
    i_read = 1'b1;
    i_addr = 16'h7000;
    @(negedge clk);
    check("rst_mid_serving", {127'd0, pmem_read}, 128'd1);
    rst    = 1'b1;
    i_read = 1'b0;
    @(negedge clk);
    check("rst_mid_read_low", {127'd0, pmem_read}, 128'd0);
    check("rst_mid_no_i_resp", {127'd0, i_resp}, 128'd0);
    check("rst_mid_i_rdata", i_rdata, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = L_D2;
    @(negedge clk);
    pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("late_resp_ignored", {126'd0, pmem_read, pmem_write}, 128'd0);
    pm_enable = 1'b1;

    // Tie again after this reset: D must win once more.
    push_cmd(1'b1, 16'h3000, L_WB); rd_q.push_back(L_ACK); exp_d_q.push_back(L_ACK);
    push_cmd(1'b0, 16'h3100, '0); rd_q.push_back(L_I2); exp_i_q.push_back(L_I2);
    fork
      run_d(16'h3000, L_WB, 1'b0, 1'b1);
      run_i(16'h3100, 1'b0);
    join
    repeat (3) @(negedge clk);

    check("cmd_queue_drained", exp_cmd_q.size(), 128'd0);
    check("i_queue_drained", exp_i_q.size(), 128'd0);
    check("d_queue_drained", exp_d_q.size(), 128'd0);
    check("rd_queue_drained", rd_q.size(), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
